// File: rtl/gpr_mp_pkg.sv
// Shared types and defaults for the multi-port GPR file: dump FSM states,
// default widths and packed slot/port slice helpers.
package gpr_mp_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 3;
  localparam int DEF_NUM_WR   = 2;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_RUN  = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

  // LSB of element `idx` in a flat bus of `width`-bit elements.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gpr_mp_rdport.sv
// One combinational read port: x0 / out-of-range zeroing and, when
// GPR_MP_BYPASS_EN is defined, same-cycle commit forwarding (youngest slot wins).
module gpr_mp_rdport
  import gpr_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
`ifdef GPR_MP_BYPASS_EN
  ,
  parameter int NUM_WR   = DEF_NUM_WR
`endif
) (
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_regs [NUM_REGS],
`ifdef GPR_MP_BYPASS_EN
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
`endif
  output logic [DATA_W-1:0]        o_data
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic              w_readable;
  logic [DATA_W-1:0] w_stored;

  // Index 0 and indices beyond the array never return stored data.
  assign w_readable = ({1'b0, i_addr} < NUM_REGS_L) && (i_addr != '0);
  assign w_stored   = w_readable ? i_regs[i_addr] : '0;

`ifdef GPR_MP_BYPASS_EN
  always_comb begin
    o_data = w_stored;
    for (int k = 0; k < NUM_WR; k++) begin
      if (i_wr_en[k] && w_readable &&
          (i_wr_addr[slice_lsb(k, ADDR_W) +: ADDR_W] == i_addr)) begin
        o_data = i_wr_data[slice_lsb(k, DATA_W) +: DATA_W];
      end
    end
  end
`else
  assign o_data = w_stored;
`endif

endmodule

// File: rtl/gpr_mp.sv
// Multi-port architectural register file with ROB commit writes, NUM_RD read
// ports and a handshaked full-register dump engine. Optional macro: GPR_MP_BYPASS_EN.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        commit_dst_en,
  input  logic [NUM_WR*ADDR_W-1:0] rob_commit_dst_addr,
  input  logic [NUM_WR*DATA_W-1:0] rob_commit_dst_value,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_en;
  logic [DATA_W-1:0] w_wr_data [NUM_REGS];

  dump_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;

  // Per-register write decode; later slots overwrite earlier ones so the
  // youngest commit to an index wins. Entry 0 is never enabled.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_en[i]   = 1'b0;
      w_wr_data[i] = '0;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (commit_dst_en[k] &&
            (rob_commit_dst_addr[slice_lsb(k, ADDR_W) +: ADDR_W] == ADDR_W'(i))) begin
          w_wr_en[i]   = 1'b1;
          w_wr_data[i] = rob_commit_dst_value[slice_lsb(k, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because architectural state must read zero.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en[i]) r_regs[i] <= w_wr_data[i];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    gpr_mp_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
`ifdef GPR_MP_BYPASS_EN
      ,
      .NUM_WR   (NUM_WR)
`endif
    ) u_rdport (
      .i_addr    (rd_addr[p*ADDR_W +: ADDR_W]),
      .i_regs    (r_regs),
`ifdef GPR_MP_BYPASS_EN
      .i_wr_en   (commit_dst_en),
      .i_wr_addr (rob_commit_dst_addr),
      .i_wr_data (rob_commit_dst_value),
`endif
      .o_data    (rd_data[p*DATA_W +: DATA_W])
    );
  end

  // Dump FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DUMP_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Dump FSM: next state. Requests outside IDLE are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      DUMP_IDLE: begin
        if (dump_req) begin
          w_state_nxt = DUMP_RUN;
          w_idx_nxt   = '0;
        end
      end
      DUMP_RUN: begin
        if (dump_ready) begin
          if (r_idx == LAST_IDX) w_state_nxt = DUMP_DONE;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
      end
      DUMP_DONE: w_state_nxt = DUMP_IDLE;
      default:   w_state_nxt = DUMP_IDLE;
    endcase
  end

  // Dump FSM: outputs. Beats always show the stored value, never bypassed data.
  always_comb begin
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    case (r_state)
      DUMP_RUN: begin
        dump_valid = 1'b1;
        dump_addr  = r_idx;
        dump_data  = r_regs[r_idx];
      end
      DUMP_DONE: dump_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Self-checking bench for gpr_mp: table-driven commit/read vectors plus
// hand-written dump, stall and mid-dump reset sequences.
module tb_gpr_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NWR-1:0]    commit_dst_en;
  logic [NWR*AW-1:0] rob_commit_dst_addr;
  logic [NWR*DW-1:0] rob_commit_dst_value;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [AW-1:0]     dump_addr;
  logic [DW-1:0]     dump_data;
  logic              dump_done;

  gpr_mp dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .commit_dst_en        (commit_dst_en),
    .rob_commit_dst_addr  (rob_commit_dst_addr),
    .rob_commit_dst_value (rob_commit_dst_value),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .dump_req             (dump_req),
    .dump_valid           (dump_valid),
    .dump_ready           (dump_ready),
    .dump_addr            (dump_addr),
    .dump_data            (dump_data),
    .dump_done            (dump_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [NR];

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  r0, r1, r2;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.en = en; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input int k, input logic en, input logic [4:0] a, input logic [31:0] d);
    commit_dst_en[k] = en;
    rob_commit_dst_addr[k*AW +: AW] = a;
    rob_commit_dst_value[k*DW +: DW] = d;
  endtask

  // Apply the currently driven commits to the bench model (slot order, x0 dropped).
  task automatic model_commit;
    for (int k = 0; k < NWR; k++) begin
      if (commit_dst_en[k] && rob_commit_dst_addr[k*AW +: AW] != 0)
        model[rob_commit_dst_addr[k*AW +: AW]] = rob_commit_dst_value[k*DW +: DW];
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!dump_valid && n < 8) begin
      tick();
      n++;
    end
    check(name, {31'd0, dump_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] byp_exp7, byp_exp8;

    rst_n = 1'b0;
    commit_dst_en = '0;
    rob_commit_dst_addr = '0;
    rob_commit_dst_value = '0;
    rd_addr = '0;
    dump_req = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    vecs[0] = mk(2'b11, 5'd5,  32'h11,   5'd5,  32'h22,   5'd5,  5'd0,  5'd6,  32'h22, 32'h0,    32'h0);
    vecs[1] = mk(2'b01, 5'd0,  32'hFFFF, 5'd9,  32'h9,    5'd0,  5'd5,  5'd0,  32'h0,  32'h22,   32'h0);
    vecs[2] = mk(2'b11, 5'd1,  32'hA,    5'd2,  32'hB,    5'd1,  5'd2,  5'd5,  32'hA,  32'hB,    32'h22);
    vecs[3] = mk(2'b10, 5'd1,  32'hDEAD, 5'd31, 32'h3131, 5'd1,  5'd31, 5'd2,  32'hA,  32'h3131, 32'hB);
    vecs[4] = mk(2'b11, 5'd31, 32'h1,    5'd0,  32'h99,   5'd31, 5'd0,  5'd31, 32'h1,  32'h0,    32'h1);
    vecs[5] = mk(2'b11, 5'd4,  32'h44,   5'd3,  32'h33,   5'd3,  5'd4,  5'd5,  32'h33, 32'h44,   32'h22);
    vecs[6] = mk(2'b00, 5'd4,  32'h0,    5'd6,  32'h0,    5'd4,  5'd6,  5'd1,  32'h44, 32'h0,    32'hA);

    // Reset state.
    #12;
    check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_dump_done",  {31'd0, dump_done},  32'd0);
    check("rst_dump_addr",  {27'd0, dump_addr},  32'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < NR; a++) begin
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = 5'(a);
      #1;
      for (int p = 0; p < NRD; p++) check($sformatf("rst_rd p%0d x%0d", p, a), rd(p), 32'h0);
    end

    // Table-driven commit/read vectors (stored values, checked after the edge).
    for (int v = 0; v < 7; v++) begin
      set_commit(0, vecs[v].en[0], vecs[v].a0, vecs[v].d0);
      set_commit(1, vecs[v].en[1], vecs[v].a1, vecs[v].d1);
      rd_addr = {vecs[v].r2, vecs[v].r1, vecs[v].r0};
      model_commit();
      tick();
      commit_dst_en = '0;
      #1;
      check($sformatf("vec%0d p0", v), rd(0), vecs[v].e0);
      check($sformatf("vec%0d p1", v), rd(1), vecs[v].e1);
      check($sformatf("vec%0d p2", v), rd(2), vecs[v].e2);
    end

    // Same-cycle commit-to-read: forwarded only with the bypass build.
`ifdef GPR_MP_BYPASS_EN
    byp_exp7 = 32'hABCD;
    byp_exp8 = 32'h2;
`else
    byp_exp7 = 32'h0;
    byp_exp8 = 32'h0;
`endif
    rd_addr = {5'd0, 5'd8, 5'd7};
    set_commit(0, 1'b1, 5'd7, 32'hABCD);
    set_commit(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("bypass x7 same cycle", rd(0), byp_exp7);
    model_commit();
    tick();
    set_commit(0, 1'b1, 5'd8, 32'h1);
    set_commit(1, 1'b1, 5'd8, 32'h2);
    #1;
    check("x7 next cycle", rd(0), 32'hABCD);
    check("bypass x8 youngest slot", rd(1), byp_exp8);
    model_commit();
    tick();
    commit_dst_en = '0;
    #1;
    check("x8 stored youngest", rd(1), 32'h2);

    // Full dump with ready held high.
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_valid("dump1 start");
    for (int b = 0; b < NR; b++) begin
      check($sformatf("dump1 addr b%0d", b), {27'd0, dump_addr}, 32'(b));
      check($sformatf("dump1 data b%0d", b), dump_data, model[b]);
      check($sformatf("dump1 done b%0d", b), {31'd0, dump_done}, 32'd0);
      tick();
    end
    check("dump1 done pulse", {31'd0, dump_done}, 32'd1);
    check("dump1 valid after", {31'd0, dump_valid}, 32'd0);
    tick();
    check("dump1 done once", {31'd0, dump_done}, 32'd0);

    // Stall at beat 3 with a commit to x3 during the stall.
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_valid("dump2 start");
    for (int b = 0; b < 3; b++) tick();
    check("stall addr pre", {27'd0, dump_addr}, 32'd3);
    check("stall data pre", dump_data, 32'h33);
    dump_ready = 1'b0;
    set_commit(0, 1'b1, 5'd3, 32'h55);
    model_commit();
    tick();
    commit_dst_en = '0;
    check("stall addr hold1", {27'd0, dump_addr}, 32'd3);
    check("stall data new", dump_data, 32'h55);
    tick();
    check("stall addr hold2", {27'd0, dump_addr}, 32'd3);
    check("stall valid hold2", {31'd0, dump_valid}, 32'd1);
    dump_ready = 1'b1;
    tick();
    for (int b = 4; b < NR; b++) begin
      check($sformatf("dump2 addr b%0d", b), {27'd0, dump_addr}, 32'(b));
      check($sformatf("dump2 data b%0d", b), dump_data, model[b]);
      tick();
    end
    check("dump2 done pulse", {31'd0, dump_done}, 32'd1);
    tick();

    // Asynchronous reset at beat 10.
    rd_addr = {5'd0, 5'd0, 5'd5};
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_valid("dump3 start");
    for (int b = 0; b < 10; b++) tick();
    check("dump3 addr b10", {27'd0, dump_addr}, 32'd10);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("rst mid valid", {31'd0, dump_valid}, 32'd0);
    check("rst mid done",  {31'd0, dump_done},  32'd0);
    check("rst mid rd x5", rd(0), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst hold done c%0d", c), {31'd0, dump_done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post rst idle", {31'd0, dump_valid}, 32'd0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_valid("dump4 start");
    check("dump4 addr b0", {27'd0, dump_addr}, 32'd0);
    check("dump4 data b0", dump_data, 32'h0);
    tick();
    check("dump4 addr b1", {27'd0, dump_addr}, 32'd1);
    check("dump4 data b1", dump_data, model[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
